// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: datapath sizes, opcode
// encodings, status-flag bit positions and the issue FSM state encoding.
// No ports (package).
package alu_pkg;

    localparam int W     = 16;
    localparam int NREGS = 8;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;

    localparam int F_SN = 4;
    localparam int F_ZR = 3;
    localparam int F_CY = 2;
    localparam int F_P  = 1;
    localparam int F_V  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Only ADD and LDI produce a register result; NOP and the reserved
    // encoding retire without touching the register file.
    function automatic logic op_writes(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction handshake bundle between an instruction source and the
// ALU issue unit.
//   instr_valid  source -> unit  instruction presented
//   instr_ready  unit -> source  unit can accept
//   instr_op     2-bit opcode (NOP/ADD/LDI/reserved)
//   instr_dst    destination register
//   instr_sa/sb  source registers (ADD)
//   instr_imm    immediate (LDI)
interface alu_issue_unit_if;
    import alu_pkg::*;

    logic         instr_valid;
    logic         instr_ready;
    logic [1:0]   instr_op;
    logic [2:0]   instr_dst;
    logic [2:0]   instr_sa;
    logic [2:0]   instr_sb;
    logic [W-1:0] instr_imm;

    modport master (
        output instr_valid, instr_op, instr_dst, instr_sa, instr_sb, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_dst, instr_sa, instr_sb, instr_imm,
        output instr_ready
    );

endinterface

// File: rtl/regfile_8x16.sv
// 8 x 16-bit register file with r0 hardwired to zero.
//   clk, rst            clock, async active-high reset (clears all entries)
//   we, waddr, wdata    synchronous write port (writes to r0 dropped)
//   ra_addr/ra_data     async read port A
//   rb_addr/rb_data     async read port B
//   rd_addr/rd_data     async read port for debug
module regfile_8x16
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [2:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [2:0]   ra_addr,
    output logic [W-1:0] ra_data,
    input  logic [2:0]   rb_addr,
    output logic [W-1:0] rb_data,
    input  logic [2:0]   rd_addr,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && (waddr != 3'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == 3'd0) ? '0 : mem[ra_addr];
    assign rb_data = (rb_addr == 3'd0) ? '0 : mem[rb_addr];
    assign rd_data = (rd_addr == 3'd0) ? '0 : mem[rd_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Operand-issue and write-back stage around an external combinational
// 16-bit ALU. Single-issue: one instruction in flight at a time.
//   clk, rst       clock, async active-high reset
//   instr          instruction handshake (slave side)
//   alu_a/alu_b    operands to the ALU, held outside EXEC
//   alu_s, alu_*   ALU sum and flags, sampled at the end of EXEC
//   flags          status {sn, ZR, CY, P, V}, updated only by ADD
//   done           one-cycle retire pulse
//   retired        wrapping count of retired instructions
//   dbg_addr/data  combinational register read-back
module alu_issue_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_issue_unit_if.slave  instr,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_s,
    input  logic             alu_sn,
    input  logic             alu_zr,
    input  logic             alu_cy,
    input  logic             alu_p,
    input  logic             alu_v,
    output logic [4:0]       flags,
    output logic             done,
    output logic [15:0]      retired,
    input  logic [2:0]       dbg_addr,
    output logic [W-1:0]     dbg_data
);

    state_t       state_q, state_d;
    logic [1:0]   op_q;
    logic [2:0]   dst_q;
    logic [W-1:0] imm_q;
    logic [W-1:0] s_q;
    logic [4:0]   fl_q;
    logic [W-1:0] rf_ra_data, rf_rb_data;
    logic         rf_we;
    logic [W-1:0] rf_wdata;
    logic         accept;

    assign accept = instr.instr_valid && instr.instr_ready;

    regfile_8x16 u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (dst_q),
        .wdata   (rf_wdata),
        .ra_addr (instr.instr_sa),
        .ra_data (rf_ra_data),
        .rb_addr (instr.instr_sb),
        .rb_data (rf_rb_data),
        .rd_addr (dbg_addr),
        .rd_data (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (instr.instr_op == OP_ADD) ? S_EXEC : S_WB;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr.instr_ready = (state_q == S_IDLE);
        rf_we             = (state_q == S_WB) && op_writes(op_q);
        rf_wdata          = (op_q == OP_ADD) ? s_q : imm_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_NOP;
            dst_q   <= '0;
            imm_q   <= '0;
            s_q     <= '0;
            fl_q    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            flags   <= '0;
            done    <= 1'b0;
            retired <= '0;
        end else begin
            done <= (state_q == S_WB);
            if (accept) begin
                op_q  <= instr.instr_op;
                dst_q <= instr.instr_dst;
                if (instr.instr_op == OP_ADD) begin
                    // Operands go straight onto the ALU inputs and stay
                    // there until the next ADD is accepted.
                    alu_a <= rf_ra_data;
                    alu_b <= rf_rb_data;
                end
                if (instr.instr_op == OP_LDI) imm_q <= instr.instr_imm;
            end
            if (state_q == S_EXEC) begin
                s_q  <= alu_s;
                fl_q <= {alu_sn, alu_zr, alu_cy, alu_p, alu_v};
            end
            if (state_q == S_WB) begin
                retired <= retired + 16'd1;
                if (op_q == OP_ADD) flags <= fl_q;
            end
        end
    end

endmodule
